uart_pkt_tx: RTL

- Parametrised UART packet transmitter.
- Serialises a NUM_BYTES-wide parallel word as consecutive 8N1-style frames, byte 0 first.
- Adds configurable data width, stop-bit count, inter-byte idle gap, busy/done handshake and optional parity.
- Sits between the AES datapath output and the RS-232 TX pin.

---
 rtl/uart_pkt_tx.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/uart_pkt_tx.sv
// UART packet transmitter: NUM_BYTES characters, byte 0 first, LSB first, start/data/[parity]/stop/[gap] frames.
// Latency: data_out drops to the start bit on the accepting edge; done pulses on the edge ending the last stop bit.
// Backpressure: tx_start is honoured only while idle (including the done cycle); requests while busy are dropped.
// Optional parity bit enabled by defining TX_PARITY_EN (PARITY_ODD selects odd parity).
module uart_pkt_tx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int NUM_BYTES    = 8,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int GAP_BITS     = 0,
    parameter int PARITY_ODD   = 0,
    localparam int IDX_W       = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           tx_start,
    input  logic [NUM_BYTES*DATA_BITS-1:0] data_in,
    output logic                           data_out,
    output logic                           busy,
    output logic                           done,
    output logic [IDX_W-1:0]               byte_idx
);

    localparam int W      = NUM_BYTES * DATA_BITS;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int MAXB   = (GAP_BITS > DATA_BITS) ? GAP_BITS : DATA_BITS;
    localparam int CNT_W  = $clog2(MAXB + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0]  STOP_LAST = CNT_W'(STOP_BITS - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_BYTES - 1);

    // Reject configurations the framing logic cannot represent.
    if (CLKS_PER_BIT < 2 || NUM_BYTES < 1 || DATA_BITS < 5 || DATA_BITS > 8 ||
        STOP_BITS < 1 || STOP_BITS > 2 || GAP_BITS < 0 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_err
        $error("uart_pkt_tx: illegal parameter value");
    end

`ifdef TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GAP} state_t;
    localparam logic PAR_ODD = (PARITY_ODD != 0);
    logic par_acc;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_GAP} state_t;
`endif

    state_t            state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [W-1:0]      shreg;

    // Frame sequencer: the next line level is registered at every bit boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            data_out <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            byte_idx <= '0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
`ifdef TX_PARITY_EN
            par_acc  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (state == S_IDLE) begin
                baud_cnt <= '0;
                bit_cnt  <= '0;
                byte_idx <= '0;
                if (tx_start) begin
                    shreg    <= data_in;
                    busy     <= 1'b1;
                    state    <= S_START;
                    data_out <= 1'b0;
                end
            end else if (baud_cnt != BAUD_LAST) begin
                baud_cnt <= baud_cnt + BAUD_W'(1);
            end else begin
                baud_cnt <= '0;
                case (state)
                    S_START: begin
                        state    <= S_DATA;
                        data_out <= shreg[0];
                        bit_cnt  <= '0;
`ifdef TX_PARITY_EN
                        par_acc  <= 1'b0;
`endif
                    end
                    S_DATA: begin
                        // The bit just sent sits at shreg[0]; shifting exposes the next one,
                        // and after the last data bit the next character is already aligned.
                        shreg <= shreg >> 1;
`ifdef TX_PARITY_EN
                        par_acc <= par_acc ^ shreg[0];
`endif
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt  <= '0;
`ifdef TX_PARITY_EN
                            state    <= S_PARITY;
                            data_out <= par_acc ^ shreg[0] ^ PAR_ODD;
`else
                            state    <= S_STOP;
                            data_out <= 1'b1;
`endif
                        end else begin
                            bit_cnt  <= bit_cnt + CNT_W'(1);
                            data_out <= shreg[1];
                        end
                    end
`ifdef TX_PARITY_EN
                    S_PARITY: begin
                        state    <= S_STOP;
                        data_out <= 1'b1;
                        bit_cnt  <= '0;
                    end
`endif
                    S_STOP: begin
                        if (bit_cnt != STOP_LAST) begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end else if (byte_idx == IDX_LAST) begin
                            state    <= S_IDLE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            data_out <= 1'b1;
                            byte_idx <= '0;
                        end else if (GAP_BITS > 0) begin
                            state   <= S_GAP;
                            bit_cnt <= '0;
                        end else begin
                            state    <= S_START;
                            data_out <= 1'b0;
                            byte_idx <= byte_idx + IDX_W'(1);
                        end
                    end
                    S_GAP: begin
                        if (bit_cnt != GAP_LAST) begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end else begin
                            state    <= S_START;
                            data_out <= 1'b0;
                            byte_idx <= byte_idx + IDX_W'(1);
                        end
                    end
                    default: begin
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        data_out <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
